// File: rtl/x_dl_pkg.sv
// rtl/x_dl_pkg.sv - shared types and constants for the delay-line requester
// Contents: FSM state enum, default measurement command byte, response length.
package x_dl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } dl_state_t;

    // Command byte that starts one delay-line measurement.
    localparam logic [7:0] DL_CMD_DEFAULT = 8'h01;

    // Number of response bytes that make up one 32-bit measurement.
    localparam int DL_RESP_BYTES = 4;

endpackage

// File: rtl/x_dl_requester_if.sv
// rtl/x_dl_requester_if.sv - request, UART byte and result signals of the requester
// Ports (slave = requester side):
//   in : i_req, i_tx_accept, i_rx_valid, i_rx_data[7:0]
//   out: o_busy, o_done, o_timeout, o_result[31:0], o_tx_valid, o_tx_data[7:0]
interface x_dl_requester_if;

    logic        i_req;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout;
    logic [31:0] o_result;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_accept;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;

    modport slave (
        input  i_req, i_tx_accept, i_rx_valid, i_rx_data,
        output o_busy, o_done, o_timeout, o_result, o_tx_valid, o_tx_data
    );

    modport master (
        output i_req, i_tx_accept, i_rx_valid, i_rx_data,
        input  o_busy, o_done, o_timeout, o_result, o_tx_valid, o_tx_data
    );

endinterface

// File: rtl/x_timeout_cnt.sv
// rtl/x_timeout_cnt.sv - inter-byte idle counter with expire flag
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clr        : force the count to zero (wins over i_en)
//   i_en         : count one idle cycle
//   o_expire     : count has reached p_limit-1
module x_timeout_cnt #(
    parameter int p_limit = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int              LP_W    = (p_limit > 1) ? $clog2(p_limit) : 1;
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(p_limit - 1);

    logic [LP_W-1:0] r_count;

    // Saturates at the last value so the expire flag stays stable until cleared.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_expire) begin
            r_count <= r_count + LP_W'(1);
        end
    end

    assign o_expire = (r_count == LP_LAST);

endmodule

// File: rtl/x_dl_requester.sv
// rtl/x_dl_requester.sv - sends a measurement command and assembles the 4-byte reply
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : i_req / o_busy / o_done / o_timeout / o_result,
//                  UART tx (o_tx_valid, o_tx_data, i_tx_accept),
//                  UART rx (i_rx_valid, i_rx_data)
module x_dl_requester
    import x_dl_pkg::*;
#(
    parameter logic [7:0] p_cmd     = DL_CMD_DEFAULT,
    parameter int         p_timeout = 50000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    x_dl_requester_if.slave bus
);

    localparam logic [1:0] LP_LAST_BYTE = 2'(DL_RESP_BYTES - 1);

    dl_state_t   r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic [31:0] r_result;
    logic [31:0] r_shift;
    logic [1:0]  r_cnt;

    logic        w_byte;
    logic        w_to_clr;
    logic        w_to_en;
    logic        w_to_expire;
    logic        w_abort;

    // Only bytes seen while collecting count; strays elsewhere are dropped.
    assign w_byte   = (r_state == ST_COLLECT) && bus.i_rx_valid;
    // Clearing on the accept edge means the first COLLECT cycle starts at zero.
    assign w_to_clr = ((r_state == ST_SEND) && bus.i_tx_accept) || w_byte;
    assign w_to_en  = (r_state == ST_COLLECT);
    // A byte on the expiry cycle takes priority over the abort.
    assign w_abort  = w_to_en && w_to_expire && !bus.i_rx_valid;

    x_timeout_cnt #(
        .p_limit (p_timeout)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_to_clr),
        .i_en     (w_to_en),
        .o_expire (w_to_expire)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_result   <= 32'h0;
            r_shift    <= 32'h0;
            r_cnt      <= 2'd0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_req) begin
                        r_state    <= ST_SEND;
                        r_busy     <= 1'b1;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= p_cmd;
                    end
                end
                ST_SEND: begin
                    if (bus.i_tx_accept) begin
                        r_state    <= ST_COLLECT;
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= 8'h00;
                        r_cnt      <= 2'd0;
                        r_shift    <= 32'h0;
                    end
                end
                ST_COLLECT: begin
                    if (w_byte) begin
                        // Right shift: first byte ends up in [7:0], last in [31:24].
                        r_shift <= {bus.i_rx_data, r_shift[31:8]};
                        r_cnt   <= r_cnt + 2'd1;
                        if (r_cnt == LP_LAST_BYTE) begin
                            r_state  <= ST_DONE;
                            r_result <= {bus.i_rx_data, r_shift[31:8]};
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                        end
                    end else if (w_abort) begin
                        r_state   <= ST_IDLE;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_timeout  = r_timeout;
    assign bus.o_result   = r_result;
    assign bus.o_tx_valid = r_tx_valid;
    assign bus.o_tx_data  = r_tx_data;

endmodule

// File: tb/tb_x_dl_requester.sv
// tb/tb_x_dl_requester.sv - directed and randomized checks of x_dl_requester
module tb_x_dl_requester;

    localparam int         P_TO  = 100;
    localparam logic [7:0] P_CMD = 8'h01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    x_dl_requester_if bus ();

    x_dl_requester #(
        .p_cmd     (P_CMD),
        .p_timeout (P_TO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_done  = 0;
    int          n_to    = 0;
    int          n_both  = 0;
    bit          mon_en  = 1'b0;
    logic [31:0] exp_result = 32'h0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.o_done === 1'b1) n_done++;
            if (bus.o_timeout === 1'b1) n_to++;
            if (bus.o_done === 1'b1 && bus.o_timeout === 1'b1) n_both++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit with_req);
        for (int k = 0; k < n; k++) begin
            bus.i_req = with_req && (k == n / 2);
            step();
            bus.i_req = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        step();
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, {31'h0, bus.o_busy}, 32'h0);
        check({tag, "_done"}, {31'h0, bus.o_done}, 32'h0);
        check({tag, "_timeout"}, {31'h0, bus.o_timeout}, 32'h0);
        check({tag, "_tx_valid"}, {31'h0, bus.o_tx_valid}, 32'h0);
        check({tag, "_tx_data"}, {24'h0, bus.o_tx_data}, 32'h0);
    endtask

    // Command phase: tx must be held for exactly n_send cycles, accepted on the last.
    task automatic start_req(input int n_send, input bit stray_rx);
        bus.i_req = 1'b1;
        step();
        bus.i_req = 1'b0;
        for (int k = 1; k <= n_send; k++) begin
            check("send_tx_valid", {31'h0, bus.o_tx_valid}, 32'h1);
            check("send_tx_data", {24'h0, bus.o_tx_data}, {24'h0, P_CMD});
            check("send_busy", {31'h0, bus.o_busy}, 32'h1);
            bus.i_tx_accept = (k == n_send);
            bus.i_rx_valid  = stray_rx && (k == 1);
            bus.i_rx_data   = 8'hEE;
            step();
            bus.i_tx_accept = 1'b0;
            bus.i_rx_valid  = 1'b0;
            bus.i_rx_data   = 8'h00;
        end
        check("collect_tx_valid", {31'h0, bus.o_tx_valid}, 32'h0);
        check("collect_tx_data", {24'h0, bus.o_tx_data}, 32'h0);
        check("collect_busy", {31'h0, bus.o_busy}, 32'h1);
    endtask

    // Reference rule: a transaction aborts iff some inter-byte silence reaches p_timeout.
    function automatic bit model_times_out(input int gaps[4]);
        for (int i = 0; i < 4; i++)
            if (gaps[i] >= P_TO) return 1'b1;
        return 1'b0;
    endfunction

    task automatic collect(input logic [31:0] word, input int gaps[4], input bit req_mid);
        bit          to_exp;
        logic [31:0] exp_new;
        int          d0;
        int          t0;
        to_exp  = model_times_out(gaps);
        exp_new = to_exp ? exp_result : word;
        d0      = n_done;
        t0      = n_to;
        for (int i = 0; i < 4; i++) begin
            if (gaps[i] >= P_TO) begin
                idle(P_TO - 1, req_mid && (i == 1));
                check("pre_timeout_flag", {31'h0, bus.o_timeout}, 32'h0);
                check("pre_timeout_busy", {31'h0, bus.o_busy}, 32'h1);
                step();
                check("timeout_flag", {31'h0, bus.o_timeout}, 32'h1);
                check("timeout_busy", {31'h0, bus.o_busy}, 32'h0);
                check("timeout_result", bus.o_result, exp_new);
                step();
                check("timeout_pulse_end", {31'h0, bus.o_timeout}, 32'h0);
                break;
            end
            idle(gaps[i], req_mid && (i == 1));
            send_byte(word[8*i +: 8]);
        end
        if (!to_exp) begin
            check("done_flag", {31'h0, bus.o_done}, 32'h1);
            check("done_result", bus.o_result, exp_new);
            check("done_busy", {31'h0, bus.o_busy}, 32'h0);
            step();
            check("done_pulse_end", {31'h0, bus.o_done}, 32'h0);
            check("idle_busy", {31'h0, bus.o_busy}, 32'h0);
        end
        check("done_count", n_done - d0, to_exp ? 32'd0 : 32'd1);
        check("timeout_count", n_to - t0, to_exp ? 32'd1 : 32'd0);
        exp_result = exp_new;
    endtask

    initial begin
        int g[4];
        int d0;
        int t0;
        bus.i_req       = 1'b0;
        bus.i_tx_accept = 1'b0;
        bus.i_rx_valid  = 1'b0;
        bus.i_rx_data   = 8'h00;

        step();
        step();
        check_quiet("reset");
        check("reset_result", bus.o_result, 32'h0);
        mon_en = 1'b1;
        rst    = 1'b0;
        step();

        // Basic transaction, accept on the third SEND cycle.
        start_req(3, 1'b0);
        g = '{2, 0, 1, 0};
        collect(32'h12345678, g, 1'b0);

        // Two bytes then silence.
        start_req(1, 1'b0);
        g = '{0, 3, P_TO, 0};
        collect(32'hDEADBEEF, g, 1'b0);

        // Stray byte in IDLE and a second request during COLLECT.
        send_byte(8'hAA);
        check("stray_idle_busy", {31'h0, bus.o_busy}, 32'h0);
        check("stray_idle_result", bus.o_result, exp_result);
        start_req(2, 1'b0);
        g = '{1, 4, 0, 2};
        collect(32'hCAFEF00D, g, 1'b1);

        // Each byte lands on the last permitted idle cycle.
        start_req(1, 1'b0);
        g = '{P_TO - 1, P_TO - 1, P_TO - 1, P_TO - 1};
        collect(32'h0BADC0DE, g, 1'b0);

        // Four bytes on consecutive cycles.
        start_req(1, 1'b0);
        g = '{0, 0, 0, 0};
        collect(32'hA1B2C3D4, g, 1'b0);

        // Reset mid-transaction.
        start_req(1, 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        d0  = n_done;
        t0  = n_to;
        rst = 1'b1;
        #1;
        check_quiet("midreset");
        check("midreset_result", bus.o_result, 32'h0);
        exp_result = 32'h0;
        step();
        step();
        check("midreset_no_done", n_done - d0, 32'd0);
        check("midreset_no_timeout", n_to - t0, 32'd0);
        rst       = 1'b0;
        bus.i_req = 1'b1;
        step();
        bus.i_req = 1'b0;
        check("postreset_busy", {31'h0, bus.o_busy}, 32'h1);
        check("postreset_tx_valid", {31'h0, bus.o_tx_valid}, 32'h1);
        bus.i_tx_accept = 1'b1;
        step();
        bus.i_tx_accept = 1'b0;
        g = '{0, 0, 0, 0};
        collect(32'h80000001, g, 1'b0);

        // Randomized transactions.
        for (int t = 0; t < 20; t++) begin
            logic [31:0] w;
            int          r;
            w = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                send_byte(8'($urandom));
                check("rnd_stray_busy", {31'h0, bus.o_busy}, 32'h0);
                check("rnd_stray_result", bus.o_result, exp_result);
            end
            start_req($urandom_range(1, 4), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 11);
                if (r == 0) g[i] = P_TO;
                else if (r == 1) g[i] = P_TO - 1;
                else g[i] = $urandom_range(0, 4);
            end
            collect(w, g, 1'($urandom_range(0, 1)));
        end

        check("done_timeout_overlap", n_both, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/x_dl_requester.md
X_DL_REQUESTER -- requirements
Module: x_dl_requester

Interface
REQ-001 Parameter p_cmd, default 8'h01: command byte sent to start one delay-line measurement.
REQ-002 Parameter p_timeout, default 50000: idle cycles allowed between response bytes before abort.
REQ-003 i_clk  input  1  single clock; all logic is rising-edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req  input  1  one-cycle request to start a measurement.
REQ-006 o_busy  output  1  high while a transaction is in progress.
REQ-007 o_done  output  1  one-cycle pulse when o_result is updated.
REQ-008 o_timeout  output  1  one-cycle pulse when a transaction is aborted.
REQ-009 o_result  output  32  last completed measurement.
REQ-010 o_tx_valid  output  1  command byte valid toward the UART transmitter.
REQ-011 o_tx_data  output  8  command byte.
REQ-012 i_tx_accept  input  1  transmitter has taken the byte.
REQ-013 i_rx_valid  input  1  one-cycle strobe: received byte present.
REQ-014 i_rx_data  input  8  received byte.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, COLLECT, DONE.
REQ-016 IDLE: i_req=1 SHALL move to SEND on the next edge; i_req in any other state SHALL be ignored, with no queuing.
REQ-017 SEND: o_tx_valid=1 and o_tx_data=p_cmd SHALL hold until the cycle in which i_tx_accept=1; the FSM SHALL then move to COLLECT with byte count 0.
REQ-018 o_tx_valid SHALL be 0 in all states other than SEND; o_tx_data SHALL be 8'h00 when o_tx_valid=0.
REQ-019 COLLECT: each i_rx_valid SHALL store i_rx_data into the shift register and increment a 2-bit byte count.
REQ-020 Bytes SHALL be received LSB first: byte 0 goes to [7:0] and byte 3 goes to [31:24].
REQ-021 On the 4th byte (count 3 plus i_rx_valid), the FSM SHALL move to DONE.
REQ-022 DONE SHALL last exactly one cycle; during DONE, o_result SHALL take the assembled word, o_done=1, and the next state SHALL be IDLE.
REQ-023 Latency: o_done SHALL be asserted the cycle after the 4th i_rx_valid.
REQ-024 The timeout counter SHALL clear on entry to COLLECT and on every i_rx_valid, and increment otherwise.
REQ-025 If the counter reaches p_timeout-1 with no i_rx_valid, the block SHALL pulse o_timeout, return to IDLE, leave o_result unchanged, and discard partial bytes.
REQ-026 If i_rx_valid coincides with the timeout cycle, the byte SHALL win and the counter SHALL clear.
REQ-027 i_rx_valid in IDLE, SEND or DONE SHALL be discarded without affecting any state.
REQ-028 SEND SHALL NOT time out; the transmitter is trusted to accept.
REQ-029 o_busy SHALL be 1 in SEND and COLLECT, and 0 in IDLE and DONE.
REQ-030 o_done and o_timeout SHALL never be asserted in the same cycle.

Reset
REQ-031 i_rst=1 SHALL immediately force IDLE and set o_busy=0, o_done=0, o_timeout=0, o_tx_valid=0, o_tx_data=0, o_result=0, byte count=0 and timeout counter=0.
REQ-032 Reset asserted mid-transaction SHALL abort the transaction with no o_done or o_timeout pulse.
REQ-033 After reset release, the first cycle SHALL accept i_req.

Structure
REQ-034 Package x_dl_pkg SHALL hold the state enum, the default command constant (8'h01), and the response byte count constant (4).
REQ-035 The timeout counter SHALL be a sub-module x_timeout_cnt (clear, enable, expire output, parameterised limit); all other logic SHALL be in x_dl_requester.

Verification
REQ-036 Basic: i_req pulse, accept after 3 cycles, bytes 78,56,34,12 -> o_tx_data=01 held 3 cycles, o_result=32'h12345678, o_done pulses 1 cycle after the 4th byte.
REQ-037 Timeout: p_timeout=100, two bytes then silence -> o_timeout pulses at 100 idle cycles, o_result unchanged, o_busy=0.
REQ-038 Stray and overlapping input: i_rx_valid with AA while IDLE, i_req during COLLECT -> AA ignored, second request ignored, result from the 4 in-window bytes only.
REQ-039 Boundary: a byte arrives exactly on the p_timeout-1 cycle -> no timeout and the transaction completes; back-to-back i_rx_valid on 4 consecutive cycles -> correct assembly.
REQ-040 Reset: i_rst asserted after 2 bytes -> outputs zero immediately, no done or timeout pulse; next transaction with bytes 01,00,00,80 -> o_result=32'h80000001.
